// File: rtl/quad_operand_sequencer.sv
// Feeds a 4:1 operand selector: holds one four-operand bundle and steps the
// select lines through the enabled lanes, one lane per downstream handshake.
module quad_operand_sequencer #(
    parameter int N = 76
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_c,
    input  logic [N-1:0] in_d,
    input  logic [3:0]   in_mask,
    output logic [N-1:0] ina,
    output logic [N-1:0] inb,
    output logic [N-1:0] inc,
    output logic [N-1:0] ind,
    output logic         s1,
    output logic         s2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   out_lane,
    output logic         out_last,
    output logic         done
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    logic [0:0]   state_q, state_d;
    logic [N-1:0] ina_q, ina_d, inb_q, inb_d;
    logic [N-1:0] inc_q, inc_d, ind_q, ind_d;
    logic [1:0]   lane_q, lane_d;
    logic [3:0]   rem_q, rem_d, rem_clr;
    logic         done_q, done_d;

    // Lowest enabled lane wins; only called with a nonzero mask.
    function automatic logic [1:0] low_lane(input logic [3:0] m);
        if (m[0])      return 2'd0;
        else if (m[1]) return 2'd1;
        else if (m[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    always_comb begin
        state_d = state_q;
        ina_d   = ina_q;
        inb_d   = inb_q;
        inc_d   = inc_q;
        ind_d   = ind_q;
        lane_d  = lane_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        rem_clr = rem_q & ~(4'b0001 << lane_q);
        if (state_q == IDLE) begin
            if (in_valid) begin
                ina_d = in_a;
                inb_d = in_b;
                inc_d = in_c;
                ind_d = in_d;
                rem_d = in_mask;
                if (in_mask != 4'd0) begin
                    state_d = ISSUE;
                    lane_d  = low_lane(in_mask);
                end else begin
                    done_d = 1'b1;
                end
            end
        end else if (out_ready) begin
            rem_d = rem_clr;
            if (rem_clr != 4'd0) begin
                lane_d = low_lane(rem_clr);
            end else begin
                state_d = IDLE;
                lane_d  = 2'd0;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ina_q   <= '0;
            inb_q   <= '0;
            inc_q   <= '0;
            ind_q   <= '0;
            lane_q  <= 2'd0;
            rem_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ina_q   <= ina_d;
            inb_q   <= inb_d;
            inc_q   <= inc_d;
            ind_q   <= ind_d;
            lane_q  <= lane_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == ISSUE);
    assign ina       = ina_q;
    assign inb       = inb_q;
    assign inc       = inc_q;
    assign ind       = ind_q;
    assign s1        = lane_q[0];
    assign s2        = lane_q[1];
    assign out_lane  = lane_q;
    assign done      = done_q;
    // Exactly one remaining bit means the current lane closes the bundle.
    assign out_last  = out_valid && (rem_q != 4'd0)
                       && ((rem_q & (rem_q - 4'd1)) == 4'd0);

endmodule

// File: tb/tb_quad_operand_sequencer.sv
// Self-checking bench for quad_operand_sequencer: directed scenarios plus
// randomized bundles checked against a lane-list reference model.
module tb_quad_operand_sequencer;

    localparam int N = 76;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a, in_b, in_c, in_d;
    logic [3:0]   in_mask;
    logic [N-1:0] ina, inb, inc, ind;
    logic         s1, s2;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_lane;
    logic         out_last;
    logic         done;

    int tests = 0;
    int fails = 0;

    quad_operand_sequencer #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .in_mask(in_mask),
        .ina(ina), .inb(inb), .inc(inc), .ind(ind),
        .s1(s1), .s2(s2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_lane(out_lane), .out_last(out_last), .done(done)
    );

    always #5 clk = ~clk;

    // Behaviour of the downstream 4:1 selector driven by the DUT.
    function automatic logic [N-1:0] mux_out();
        case ({s2, s1})
            2'd0:    return ina;
            2'd1:    return inb;
            2'd2:    return inc;
            default: return ind;
        endcase
    endfunction

    function automatic logic [N-1:0] rnd_op();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[N-1:0];
    endfunction

    // Offers one bundle at the current negedge and follows it to completion.
    // The model: lanes issue in ascending order of set mask bits, the
    // selector shows that lane's operand, the last set bit is out_last.
    task automatic drive_bundle(input logic [N-1:0] a, b, c, d,
                                input logic [3:0] m, input int stall_lane,
                                input int stall_n, input bit rnd);
        logic [N-1:0] op[4];
        int lanes[$];
        int stalls;
        bit last;
        op[0] = a; op[1] = b; op[2] = c; op[3] = d;
        for (int i = 0; i < 4; i++) if (m[i]) lanes.push_back(i);

        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL accept_ready: got %b want 1", in_ready);
        end
        in_valid = 1'b1;
        in_a = a; in_b = b; in_c = c; in_d = d; in_mask = m;
        @(negedge clk);
        in_valid = 1'b0;
        in_a = rnd_op(); in_mask = 4'($urandom);

        tests++;
        if (out_valid !== (lanes.size() != 0)) begin
            fails++;
            $display("FAIL first_valid: got %b want %b",
                     out_valid, lanes.size() != 0);
        end
        tests++;
        if (done !== (lanes.size() == 0)) begin
            fails++;
            $display("FAIL accept_done: got %b want %b",
                     done, lanes.size() == 0);
        end
        if (lanes.size() == 0) begin
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL zero_ready: got %b want 1", in_ready);
            end
            return;
        end

        for (int j = 0; j < lanes.size(); j++) begin
            last = (j == lanes.size() - 1);
            if (lanes[j] == stall_lane) stalls = stall_n;
            else stalls = rnd ? int'($urandom_range(0, 2)) : 0;
            for (int k = 0; k <= stalls; k++) begin
                out_ready = (k == stalls);
                if (rnd) begin
                    in_valid = 1'($urandom);
                    in_a = rnd_op();
                    in_d = rnd_op();
                end
                tests++;
                if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL issue_hs: valid %b ready %b want 1/0",
                             out_valid, in_ready);
                end
                tests++;
                if (out_lane !== 2'(lanes[j]) || {s2, s1} !== 2'(lanes[j])) begin
                    fails++;
                    $display("FAIL lane: out_lane %0d sel %0d want %0d",
                             out_lane, {s2, s1}, lanes[j]);
                end
                tests++;
                if (mux_out() !== op[lanes[j]]) begin
                    fails++;
                    $display("FAIL sel_data: got %h want %h",
                             mux_out(), op[lanes[j]]);
                end
                tests++;
                if ({ina, inb, inc, ind} !== {op[0], op[1], op[2], op[3]}) begin
                    fails++;
                    $display("FAIL operands_held: lane %0d", lanes[j]);
                end
                tests++;
                if (out_last !== last || done !== 1'b0) begin
                    fails++;
                    $display("FAIL last_done: last %b done %b want %b/0",
                             out_last, done, last);
                end
                @(negedge clk);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'($urandom);

        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || done !== 1'b1) begin
            fails++;
            $display("FAIL finish: valid %b ready %b done %b want 0/1/1",
                     out_valid, in_ready, done);
        end
        tests++;
        if ({s2, s1, out_last} !== 3'b000) begin
            fails++;
            $display("FAIL idle_sel: s2s1last %b want 000", {s2, s1, out_last});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_mask = 4'd0;
        in_a = '0; in_b = '0; in_c = '0; in_d = '0;
        repeat (2) @(negedge clk);
        tests++;
        if ({ina, inb, inc, ind} !== '0 ||
            {s1, s2, out_valid, out_last, done} !== 5'b0) begin
            fails++;
            $display("FAIL reset_outs: v%b l%b d%b", out_valid, out_last, done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: ready %b valid %b done %b",
                     in_ready, out_valid, done);
        end
    endtask

    task automatic test_full_bundle();
        drive_bundle(1, 2, 3, 4, 4'b1111, -1, 0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_sparse();
        drive_bundle(rnd_op(), rnd_op(), rnd_op(), rnd_op(), 4'b1010,
                     -1, 0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        drive_bundle(rnd_op(), rnd_op(), rnd_op(), rnd_op(), 4'b0111,
                     1, 3, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_zero_mask();
        drive_bundle(rnd_op(), rnd_op(), rnd_op(), rnd_op(), 4'b0000,
                     -1, 0, 1'b0);
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL zero_after: done %b valid %b ready %b",
                     done, out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_mask = 4'b1111;
        in_a = 10; in_b = 11; in_c = 12; in_d = 13;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        tests++;
        if (out_lane !== 2'd2 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL mid_lane: lane %0d valid %b want 2/1",
                     out_lane, out_valid);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({ina, inb, inc, ind} !== '0 ||
            {s1, s2, out_valid, out_last, done} !== 5'b0) begin
            fails++;
            $display("FAIL mid_reset: lane %0d v%b l%b d%b",
                     out_lane, out_valid, out_last, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_release: done %b ready %b valid %b",
                     done, in_ready, out_valid);
        end
        drive_bundle(9, rnd_op(), rnd_op(), rnd_op(), 4'b0001, -1, 0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        drive_bundle(rnd_op(), rnd_op(), rnd_op(), 77, 4'b1000, -1, 0, 1'b0);
        drive_bundle(5, 6, 7, 8, 4'b0110, -1, 0, 1'b0);
        drive_bundle(rnd_op(), rnd_op(), rnd_op(), rnd_op(), 4'b1001,
                     -1, 0, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            drive_bundle(rnd_op(), rnd_op(), rnd_op(), rnd_op(),
                         4'($urandom), -1, 0, 1'b1);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_full_bundle();
        test_sparse();
        test_backpressure();
        test_zero_mask();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/quad_operand_sequencer.md
Name: quad_operand_sequencer

Overview:
- Upstream stage of the 4:1 N-bit operand selector (`MUXS`). Accepts one bundle of four N-bit operands plus a lane-enable mask via valid/ready.
- Holds the four operands stable on the selector's data inputs and steps the two select lines (S1, S2) through the enabled lanes in ascending order, one lane per downstream handshake.
- Presents `out_valid`, `out_lane` and `out_last` alongside the selector output, so the consumer needs no knowledge of the select encoding.

Parameters:
- N, 76, operand width in bits; must equal the selector's N.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream bundle valid
- in_ready  output  1  sequencer can accept a bundle
- in_a  input  N  lane 0 operand
- in_b  input  N  lane 1 operand
- in_c  input  N  lane 2 operand
- in_d  input  N  lane 3 operand
- in_mask  input  4  lane enables; bit i enables lane i
- ina  output  N  registered lane 0, to selector INA
- inb  output  N  registered lane 1, to selector INB
- inc  output  N  registered lane 2, to selector INC
- ind  output  N  registered lane 3, to selector IND
- s1  output  1  selector S1 (lane index bit 0)
- s2  output  1  selector S2 (lane index bit 1)
- out_valid  output  1  selector output holds a valid lane
- out_ready  input  1  downstream accepts current lane
- out_lane  output  2  index of current lane, equals {s2,s1}
- out_last  output  1  current lane is the last enabled lane of the bundle
- done  output  1  one-cycle pulse after the final lane handshake of a bundle

Behaviour:
- Reset (`rst_n` low, asynchronous):
  - state is IDLE.
  - `ina`/`inb`/`inc`/`ind` are 0.
  - `s1`, `s2`, `out_valid`, `out_last` and `done` are 0.
  - Remaining-mask register is 0.
  - `in_ready` is 1 once reset is released.
- Lane encoding: lane = {s2,s1}; 0 selects INA, 1 INB, 2 INC, 3 IND.
- States: IDLE and ISSUE.
- IDLE:
  - `in_ready` = 1, `out_valid` = 0.
  - On `in_valid` && `in_ready`, capture `in_a`..`in_d` into `ina`..`ind` and `in_mask` into `rem_mask`.
  - If `in_mask` != 0: set {s2,s1} to the lowest set bit of `in_mask` and go to ISSUE. `out_valid` rises the cycle after acceptance (1-cycle latency).
  - If `in_mask` == 0: stay in IDLE and pulse `done` the next cycle. No lane is issued.
- ISSUE:
  - `in_ready` = 0 and `out_valid` = 1.
  - `ina`..`ind`, `s1` and `s2` hold stable while `out_valid` && !`out_ready`.
  - `out_last` = 1 iff `rem_mask` has exactly one bit set (the current lane).
  - On `out_valid` && `out_ready`: clear the current lane's bit in `rem_mask`.
    - If other bits remain, set {s2,s1} to the next-lowest remaining bit and stay in ISSUE. Back-to-back lanes issue one per cycle when `out_ready` is held high.
    - If none remain, go to IDLE with `out_valid` = 0, and pulse `done` for exactly one cycle (the cycle after the final handshake).
- A new bundle cannot be accepted in the same cycle as the final lane handshake; `in_ready` returns on the following cycle.
- Operands are never modified in ISSUE; `in_a`..`in_d` are ignored outside IDLE.
- `out_ready` is ignored while `out_valid` = 0.
- `in_valid` is ignored while `in_ready` = 0; the upstream must hold the bundle.
- Reset asserted mid-bundle: the bundle is abandoned, all outputs return to reset values immediately, and no `done` pulse is generated.
- `out_lane` is combinationally equal to {s2,s1}. `s1`/`s2` are 0 whenever `out_valid` = 0.

Test Plan:
- Full bundle, `out_ready` held 1: a=1, b=2, c=3, d=4, mask=4'b1111.
  - Lanes 0,1,2,3 issue on four consecutive cycles starting 1 cycle after acceptance.
  - Selector output reads 1,2,3,4; `out_last` is high only with lane 3; `done` pulses one cycle after lane 3.
- Sparse mask 4'b1010: lanes 1 then 3 only; {s2,s1} = 01 then 11; `out_last` is high on lane 3.
- Backpressure: mask 4'b0111 with `out_ready` low for 3 cycles on lane 1.
  - {s2,s1} = 01 and `ina`..`ind` stay constant for those cycles; lane 2 issues the cycle after `out_ready` returns.
- Zero mask: `in_valid` with mask=0.
  - Accepted with `out_valid` never asserted; `done` pulses 1 cycle later; `in_ready` stays 1.
- Reset mid-bundle: assert `rst_n` = 0 while lane 2 of mask 4'b1111 is pending.
  - All outputs are 0 immediately with no `done` pulse; after release, a new bundle with a=9, mask=4'b0001 issues lane 0 with the selector showing 9.
- Single-lane boundary with back-to-back bundles:
  - Bundle mask=4'b1000 issues lane 3 with `out_last` = 1.
  - `in_ready` stays 0 in the handshake cycle and is 1 the next cycle; the second bundle is accepted then.
